// File: rtl/wb_arb2_if.sv
// Wishbone pipelined bus bundle shared by the arbiter's requester and slave sides.
// The master modport drives the request fields; the slave modport drives the response.
interface if_wb #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic            cyc;
  logic            stb;
  logic            we;
  logic [DW/8-1:0] sel;
  logic [AW-1:0]   adr;
  logic [DW-1:0]   dat_m;
  logic            ack;
  logic            stall;
  logic [DW-1:0]   dat_s;

  modport master (output cyc, stb, we, sel, adr, dat_m, input ack, stall, dat_s);
  modport slave  (input cyc, stb, we, sel, adr, dat_m, output ack, stall, dat_s);
endinterface

// File: rtl/wb_arb2.sv
// Two-master, one-slave Wishbone arbiter with round-robin tie break, grant held for a whole
// cycle, outstanding-request tracking, abort detection and saturating per-master ack counters.
module wb_arb2 #(
  parameter int CNTW = 16,
  parameter int OUTW = 4
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  if_wb.slave             m0,
  if_wb.slave             m1,
  if_wb.master            s,
  output logic [1:0]      grant_o,
  output logic            abort_o,
  output logic [CNTW-1:0] cnt0_o,
  output logic [CNTW-1:0] cnt1_o
);

  typedef enum logic [1:0] {IDLE = 2'd0, G0 = 2'd1, G1 = 2'd2} state_t;

  localparam logic [OUTW-1:0] OUT_MAX = '1;
  localparam logic [OUTW-1:0] OUT_ONE = {{(OUTW-1){1'b0}}, 1'b1};
  localparam logic [CNTW-1:0] CNT_MAX = '1;
  localparam logic [CNTW-1:0] CNT_ONE = {{(CNTW-1){1'b0}}, 1'b1};

  state_t          state_reg, state_next;
  logic            last_reg, last_next;
  logic [OUTW-1:0] out_reg, out_next;
  logic            abort_reg, abort_next;
  logic [CNTW-1:0] cnt0_reg, cnt0_next;
  logic [CNTW-1:0] cnt1_reg, cnt1_next;
  logic            g0, g1, accept, ack_ok, drop;

  assign g0 = (state_reg == G0);
  assign g1 = (state_reg == G1);

  always_comb begin
    s.cyc   = 1'b0;
    s.stb   = 1'b0;
    s.we    = 1'b0;
    s.sel   = '0;
    s.adr   = '0;
    s.dat_m = '0;
    if (g0) begin
      s.cyc   = m0.cyc;
      s.stb   = m0.stb;
      s.we    = m0.we;
      s.sel   = m0.sel;
      s.adr   = m0.adr;
      s.dat_m = m0.dat_m;
    end else if (g1) begin
      s.cyc   = m1.cyc;
      s.stb   = m1.stb;
      s.we    = m1.we;
      s.sel   = m1.sel;
      s.adr   = m1.adr;
      s.dat_m = m1.dat_m;
    end
  end

  // An ack only counts when something is owed to the current owner; late acks after an abort die here.
  assign accept = s.cyc & s.stb & ~s.stall;
  assign ack_ok = s.cyc & s.ack & ((out_reg != '0) | accept);
  assign drop   = (g0 & ~m0.cyc) | (g1 & ~m1.cyc);

  assign m0.ack   = g0 & ack_ok;
  assign m0.stall = g0 ? s.stall : 1'b1;
  assign m0.dat_s = g0 ? s.dat_s : '0;
  assign m1.ack   = g1 & ack_ok;
  assign m1.stall = g1 ? s.stall : 1'b1;
  assign m1.dat_s = g1 ? s.dat_s : '0;

  always_comb begin
    state_next = state_reg;
    last_next  = last_reg;
    out_next   = out_reg;
    abort_next = 1'b0;
    cnt0_next  = cnt0_reg;
    cnt1_next  = cnt1_reg;

    case (state_reg)
      IDLE: begin
        if (m0.cyc && (!m1.cyc || last_reg)) begin
          state_next = G0;
          last_next  = 1'b0;
        end else if (m1.cyc) begin
          state_next = G1;
          last_next  = 1'b1;
        end
      end
      G0: begin
        if (!m0.cyc) begin
          if (m1.cyc) begin
            state_next = G1;
            last_next  = 1'b1;
          end else begin
            state_next = IDLE;
          end
        end
      end
      G1: begin
        if (!m1.cyc) begin
          if (m0.cyc) begin
            state_next = G0;
            last_next  = 1'b0;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase

    if (accept && !ack_ok) begin
      if (out_reg != OUT_MAX) out_next = out_reg + OUT_ONE;
    end else if (!accept && ack_ok) begin
      if (out_reg != '0) out_next = out_reg - OUT_ONE;
    end

    if (drop) begin
      abort_next = (out_reg != '0);
      out_next   = '0;
    end

    if (g0 && ack_ok && cnt0_reg != CNT_MAX) cnt0_next = cnt0_reg + CNT_ONE;
    if (g1 && ack_ok && cnt1_reg != CNT_MAX) cnt1_next = cnt1_reg + CNT_ONE;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg <= IDLE;
      last_reg  <= 1'b1;
      out_reg   <= '0;
      abort_reg <= 1'b0;
      cnt0_reg  <= '0;
      cnt1_reg  <= '0;
    end else begin
      state_reg <= state_next;
      last_reg  <= last_next;
      out_reg   <= out_next;
      abort_reg <= abort_next;
      cnt0_reg  <= cnt0_next;
      cnt1_reg  <= cnt1_next;
    end
  end

  assign grant_o = {g1, g0};
  assign abort_o = abort_reg;
  assign cnt0_o  = cnt0_reg;
  assign cnt1_o  = cnt1_reg;

endmodule

// File: tb/tb_wb_arb2.sv
// Directed plus randomized bench for wb_arb2; the reference model tracks round-robin order,
// bus ownership and expected ack counts with plain variables and a queue of pending beats.
module tb_wb_arb2;
  logic clk_i = 1'b0;
  logic rst_ni = 1'b0;
  logic [1:0]  grant_o;
  logic        abort_o;
  logic [15:0] cnt0_o, cnt1_o;

  if_wb m0_if ();
  if_wb m1_if ();
  if_wb s_if ();

  wb_arb2 dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .m0     (m0_if),
    .m1     (m1_if),
    .s      (s_if),
    .grant_o(grant_o),
    .abort_o(abort_o),
    .cnt0_o (cnt0_o),
    .cnt1_o (cnt1_o)
  );

  always #5 clk_i = ~clk_i;

  int          total = 0;
  int          bad = 0;
  bit          last_m = 1'b1;
  logic [15:0] exp_cnt [2];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_m(input int i, input logic cyc, input logic stb, input logic we,
                       input logic [31:0] adr, input logic [31:0] dat);
    if (i == 0) begin
      m0_if.cyc = cyc; m0_if.stb = stb; m0_if.we = we; m0_if.sel = 4'hF;
      m0_if.adr = adr; m0_if.dat_m = dat;
    end else begin
      m1_if.cyc = cyc; m1_if.stb = stb; m1_if.we = we; m1_if.sel = 4'hF;
      m1_if.adr = adr; m1_if.dat_m = dat;
    end
  endtask

  // {ack, stall, dat_s} as seen by master i
  function automatic logic [33:0] get_m(input int i);
    if (i == 0) return {m0_if.ack, m0_if.stall, m0_if.dat_s};
    return {m1_if.ack, m1_if.stall, m1_if.dat_s};
  endfunction

  function automatic logic [15:0] cnt_of(input int i);
    return (i == 0) ? cnt0_o : cnt1_o;
  endfunction

  // Master i owns the bus; run k beats, slave data for address a is seed + (a - base).
  task automatic burst(input int i, input int k, input logic [31:0] base, input logic [31:0] seed,
                       input bit hold, input bit rnd, output int peak);
    int          issued = 0, acked = 0, pend = 0, cycles = 0;
    logic [31:0] q[$];
    logic        st, ak, we;
    logic [31:0] exp_dat;
    logic [33:0] r, ro;
    peak = 0;
    while (acked < k && cycles < 200) begin
      st = rnd ? ($urandom_range(0, 3) == 0) : 1'b0;
      ak = (pend > 0) && (!hold || issued == k) && (rnd ? ($urandom_range(0, 1) == 1) : 1'b1);
      we = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
      exp_dat = 32'h0;
      if (ak) exp_dat = seed + (q[0] - base);
      set_m(i, 1'b1, issued < k, we, base + issued, ~(base + issued));
      s_if.stall = st;
      s_if.ack   = ak;
      s_if.dat_s = exp_dat;
      #1;
      r  = get_m(i);
      ro = get_m(1 - i);
      chk("m_stall", {63'd0, r[32]}, {63'd0, st});
      chk("m_ack", {63'd0, r[33]}, {63'd0, ak});
      if (ak) chk("m_dat", {32'd0, r[31:0]}, {32'd0, exp_dat});
      chk("other_stall", {63'd0, ro[32]}, 64'd1);
      chk("other_ack", {63'd0, ro[33]}, 64'd0);
      chk("other_dat", {32'd0, ro[31:0]}, 64'd0);
      chk("s_adr", {32'd0, s_if.adr}, {32'd0, base + issued});
      chk("s_dat_m", {32'd0, s_if.dat_m}, {32'd0, ~(base + issued)});
      chk("s_we_sel", {59'd0, s_if.we, s_if.sel}, {59'd0, we, 4'hF});
      chk("abort_idle", {63'd0, abort_o}, 64'd0);
      if (issued < k && !st) begin
        q.push_back(base + issued);
        issued++;
        pend++;
      end
      if (ak) begin
        void'(q.pop_front());
        pend--;
        acked++;
        if (exp_cnt[i] != 16'hFFFF) exp_cnt[i]++;
      end
      if (pend > peak) peak = pend;
      tick();
      cycles++;
      chk("outstanding", {60'd0, dut.out_reg}, pend);
    end
    s_if.ack = 1'b0;
    s_if.stall = 1'b0;
    set_m(i, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("burst_done", acked, k);
    chk("cnt", {48'd0, cnt_of(i)}, {48'd0, exp_cnt[i]});
  endtask

  // One arbitration round: requesters raise cyc together, winner served, then the other.
  task automatic round(input bit r0, input bit r1, input int k0, input int k1,
                       input logic [31:0] base, input logic [31:0] seed,
                       input bit hold, input bit rnd, output int peak);
    int first, second, pk;
    peak = 0;
    set_m(0, r0, 1'b0, 1'b0, 32'h0, 32'h0);
    set_m(1, r1, 1'b0, 1'b0, 32'h0, 32'h0);
    s_if.ack = 1'b0;
    s_if.stall = 1'b0;
    if (r0 && r1) first = last_m ? 0 : 1;
    else          first = r0 ? 0 : 1;
    second = (r0 && r1) ? 1 - first : -1;
    tick();
    chk("grant_first", {62'd0, grant_o}, (first == 0) ? 64'd1 : 64'd2);
    last_m = (first == 1);
    burst(first, (first == 0) ? k0 : k1, base, seed, hold, rnd, pk);
    peak = pk;
    set_m(first, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    chk("abort_clean", {63'd0, abort_o}, 64'd0);
    if (second >= 0) begin
      chk("grant_handover", {62'd0, grant_o}, (second == 0) ? 64'd1 : 64'd2);
      last_m = (second == 1);
      burst(second, (second == 0) ? k0 : k1, base + 32'h100, seed ^ 32'h5A5A_0000, hold, rnd, pk);
      if (pk > peak) peak = pk;
      set_m(second, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      tick();
    end
    chk("grant_idle", {62'd0, grant_o}, 64'd0);
  endtask

  initial begin
    int          pk;
    logic [1:0]  m;
    logic [33:0] r;
    exp_cnt[0] = 16'd0;
    exp_cnt[1] = 16'd0;
    set_m(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    set_m(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    s_if.ack = 1'b0; s_if.stall = 1'b0; s_if.dat_s = 32'h0;

    // Reset state
    tick(); tick();
    chk("rst_grant", {62'd0, grant_o}, 64'd0);
    chk("rst_abort", {63'd0, abort_o}, 64'd0);
    chk("rst_cnts", {32'd0, cnt1_o, cnt0_o}, 64'd0);
    chk("rst_s_ctl", {61'd0, s_if.cyc, s_if.stb, s_if.we}, 64'd0);
    r = get_m(0);
    chk("rst_m0", {30'd0, r}, {30'd0, 2'b01, 32'd0});
    r = get_m(1);
    chk("rst_m1", {30'd0, r}, {30'd0, 2'b01, 32'd0});
    rst_ni = 1'b1;
    tick();

    // Single m0 read at 0x10 returning 0xDEADBEEF
    round(1'b1, 1'b0, 1, 0, 32'h10, 32'hDEADBEEF, 1'b0, 1'b0, pk);
    chk("single_cnt0", {48'd0, cnt0_o}, 64'd1);

    // Simultaneous requests, four times: grants alternate with no idle on handover
    for (int n = 0; n < 4; n++)
      round(1'b1, 1'b1, 1, 1, 32'h40 + 32'(n), 32'h1000 * 32'(n + 1), 1'b0, 1'b0, pk);

    // Pipelined burst of 4 on m1 before any ack
    round(1'b0, 1'b1, 0, 4, 32'h200, 32'h1234_0000, 1'b1, 1'b0, pk);
    chk("burst_peak", pk, 4);

    // Abort: m0 drops cyc with two beats outstanding while m1 waits
    set_m(0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    chk("abort_grant0", {62'd0, grant_o}, 64'd1);
    last_m = 1'b0;
    set_m(1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    for (int n = 0; n < 2; n++) begin
      set_m(0, 1'b1, 1'b1, 1'b0, 32'h300 + 32'(n), 32'h0);
      tick();
    end
    chk("abort_outst", {60'd0, dut.out_reg}, 64'd2);
    set_m(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    chk("abort_pulse", {63'd0, abort_o}, 64'd1);
    chk("abort_handover", {62'd0, grant_o}, 64'd2);
    chk("abort_outst_clr", {60'd0, dut.out_reg}, 64'd0);
    last_m = 1'b1;
    for (int n = 0; n < 2; n++) begin
      s_if.ack = 1'b1;
      s_if.dat_s = 32'hBAD0_0000 + 32'(n);
      #1;
      chk("late_ack_m0", {63'd0, m0_if.ack}, 64'd0);
      chk("late_ack_m1", {63'd0, m1_if.ack}, 64'd0);
      tick();
      chk("abort_once", {63'd0, abort_o}, 64'd0);
    end
    set_m(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    #1;
    chk("late_ack_idle", {62'd0, m1_if.ack, m0_if.ack}, 64'd0);
    s_if.ack = 1'b0;
    chk("abort_cnts", {32'd0, cnt1_o, cnt0_o}, {32'd0, exp_cnt[1], exp_cnt[0]});

    // Randomized rounds
    for (int n = 0; n < 12; n++) begin
      m = 2'($urandom_range(1, 3));
      round(m[0], m[1], $urandom_range(1, 3), $urandom_range(1, 3),
            32'h1000 + 32'(n * 16), $urandom, 1'b0, 1'b1, pk);
    end
    chk("rand_cnts", {32'd0, cnt1_o, cnt0_o}, {32'd0, exp_cnt[1], exp_cnt[0]});

    // Counter saturation near all-ones
    force dut.cnt0_reg = 16'hFFFD;
    #1;
    release dut.cnt0_reg;
    exp_cnt[0] = 16'hFFFD;
    chk("sat_preload", {48'd0, cnt0_o}, 64'hFFFD);
    round(1'b1, 1'b0, 4, 0, 32'h500, 32'h0, 1'b0, 1'b0, pk);
    chk("sat_hold", {48'd0, cnt0_o}, 64'hFFFF);

    // Reset asserted mid-transfer
    set_m(0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    set_m(0, 1'b1, 1'b1, 1'b0, 32'h600, 32'h0);
    tick();
    s_if.ack = 1'b1;
    #1;
    chk("pre_rst_scyc", {63'd0, s_if.cyc}, 64'd1);
    rst_ni = 1'b0;
    #1;
    chk("mid_rst_scyc", {63'd0, s_if.cyc}, 64'd0);
    chk("mid_rst_grant", {62'd0, grant_o}, 64'd0);
    chk("mid_rst_cnts", {32'd0, cnt1_o, cnt0_o}, 64'd0);
    chk("mid_rst_m0", {62'd0, m0_if.ack, m0_if.stall}, 64'd1);
    set_m(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    s_if.ack = 1'b0;
    tick();
    rst_ni = 1'b1;
    last_m = 1'b1;
    exp_cnt[0] = 16'd0;
    exp_cnt[1] = 16'd0;
    tick();
    round(1'b1, 1'b1, 1, 2, 32'h700, 32'hCAFE_0000, 1'b0, 1'b0, pk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
